// File: rtl/ssd_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver_pkg
// Shared constants for the multiplexed seven-segment scan driver.
//   SEG_TABLE_AL : hex digit -> segment pattern, active-low, bits {G,F,E,D,C,B,A}
//   SEG_OFF_AL   : all segments dark, active-low form
//   seg_lookup_al: table lookup helper used by the decoder
// ---------------------------------------------------------------------------
package ssd_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    // Entry 15 first so that SEG_TABLE_AL[n] is the pattern for digit n.
    localparam logic [15:0][6:0] SEG_TABLE_AL = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg_lookup_al(input logic [3:0] nib);
        return SEG_TABLE_AL[nib];
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// ---------------------------------------------------------------------------
// ssd_hex_decode
// Combinational 4-bit hex digit to 7-segment pattern decoder.
//   ACTIVE_LOW : 1 -> a lit segment is driven 0, 0 -> a lit segment is driven 1
//   i_nib      : hex digit to display
//   o_seg      : segment pattern {G,F,E,D,C,B,A} in the selected polarity
// ---------------------------------------------------------------------------
module ssd_hex_decode
    import ssd_scan_driver_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = seg_lookup_al(i_nib);
        if (!ACTIVE_LOW) begin
            o_seg = ~o_seg;
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
// Time-multiplexed driver for a NUM_DIGITS seven-segment display. A prescaler
// divides clk into digit slots of REFRESH_DIV cycles; the digit index steps
// once per slot. New values are captured on load into a pending register and
// only copied to the display register at a frame boundary, so a frame never
// shows a mix of old and new digits. Leading zeros can be blanked, and the
// first cycle of every slot keeps all digit enables off to avoid ghosting.
//   clk, reset_n : clock, synchronous active-low reset
//   value        : hex digits, digit k at value[4k+3:4k], digit 0 rightmost
//   dp_in        : decimal point request per digit
//   load         : one-cycle strobe capturing value and dp_in
//   blank_lz     : enable leading-zero blanking
//   seg, dp, an  : registered segment, decimal point and digit enable outputs
//   pending      : a captured value is waiting for the next frame boundary
// ---------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? SEG_OFF_AL : 7'b0000000;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic                  DP_OFF     = ACTIVE_LOW;

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_index;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_frame_start;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic [NUM_DIGITS-1:0]   w_an_onehot;
    logic [NUM_DIGITS-1:0]   w_an_active;
    logic [NUM_DIGITS-1:0]   w_blank_mask;
    logic                    w_cur_blank;
    logic [6:0]              w_dec_seg;

    assign w_tick        = (r_presc == PRESC_LAST);
    assign w_frame_start = w_tick && (r_index == IDX_LAST);
    assign w_an_onehot   = NUM_DIGITS'(1) << r_index;
    assign w_an_active   = ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
    assign w_cur_blank   = |(w_blank_mask & w_an_onehot);

    // Select the nibble and decimal point of the digit currently scanned.
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_index == IW'(k)) begin
                w_cur_nib = r_disp_val[4*k +: 4];
                w_cur_dp  = r_disp_dp[k];
            end
        end
    end

    // A digit is blanked when it and every digit above it are zero; the scan
    // runs from the top digit down, accumulating the "all zero so far" flag.
    always_comb begin : blank_calc
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            v_upper_zero    = v_upper_zero && (r_disp_val[4*k +: 4] == 4'h0);
            w_blank_mask[k] = blank_lz && v_upper_zero;
        end
    end

    ssd_hex_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .i_nib (w_cur_nib),
        .o_seg (w_dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc    <= '0;
            r_index    <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pending  <= 1'b0;
            r_seg      <= SEG_OFF;
            r_dp       <= DP_OFF;
            r_an       <= AN_OFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_index <= (r_index == IDX_LAST) ? '0 : r_index + IW'(1);
            end

            // A load on the frame boundary bypasses the pending register so
            // the newest value is shown without waiting a further frame.
            if (load && w_frame_start) begin
                r_disp_val <= value;
                r_disp_dp  <= dp_in;
                r_pending  <= 1'b0;
            end else if (w_frame_start && r_pending) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
                r_pending  <= 1'b0;
            end else if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pending  <= 1'b1;
            end

            // Outputs lag the index by one cycle, so the cycle after a tick
            // (prescaler back at 0) is the dead cycle: enables and dp held off.
            r_seg <= w_cur_blank ? SEG_OFF : w_dec_seg;
            r_an  <= (w_tick || w_cur_blank) ? AN_OFF : w_an_active;
            r_dp  <= (w_tick || w_cur_blank || !w_cur_dp) ? DP_OFF : ~DP_OFF;
        end
    end

    assign seg     = r_seg;
    assign dp      = r_dp;
    assign an      = r_an;
    assign pending = r_pending;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value    (value),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .pending  (pending)
    );

    // Segment patterns written out from the display's digit shapes.
    localparam logic [6:0] TB_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [3:0] AN_SEQ [18] = '{
        4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
        4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE
    };

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time since reset is a plain cycle count; slot and digit come from
    // division, display contents are whole-value variables.
    int          m_cyc;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    logic        m_pending;
    int          md_phase, md_digit;
    bit          md_tick, md_fs, md_blank;
    logic [3:0]  md_nib;

    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_pending;
    bit          exp_valid = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_cyc       = 0;
            m_disp      = '0;
            m_pend      = '0;
            m_disp_dp   = '0;
            m_pend_dp   = '0;
            m_pending   = 1'b0;
            exp_seg     = 7'h7F;
            exp_dp      = 1'b1;
            exp_an      = 4'hF;
            exp_pending = 1'b0;
            exp_valid   = 1'b1;
        end else begin
            md_phase = m_cyc % DIV;
            md_digit = (m_cyc / DIV) % N;
            md_tick  = (md_phase == DIV - 1);
            md_fs    = md_tick && (md_digit == N - 1);
            md_nib   = 4'(m_disp >> (4 * md_digit));
            md_blank = blank_lz && (md_digit != 0) && ((m_disp >> (4 * md_digit)) == 16'h0);

            exp_seg = md_blank ? 7'h7F : TB_SEG[md_nib];
            exp_an  = (md_tick || md_blank) ? 4'hF : ~(4'b0001 << md_digit);
            exp_dp  = (md_tick || md_blank || !m_disp_dp[md_digit]);

            if (load && md_fs) begin
                m_disp    = value;
                m_disp_dp = dp_in;
                m_pending = 1'b0;
            end else if (md_fs && m_pending) begin
                m_disp    = m_pend;
                m_disp_dp = m_pend_dp;
                m_pending = 1'b0;
            end else if (load) begin
                m_pend    = value;
                m_pend_dp = dp_in;
                m_pending = 1'b1;
            end
            exp_pending = m_pending;
            m_cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_seg", 32'(seg), 32'(exp_seg));
            check("model_dp", 32'(dp), 32'(exp_dp));
            check("model_an", 32'(an), 32'(exp_an));
            check("model_pending", 32'(pending), 32'(exp_pending));
        end
    end

    // ---------------- driver tasks ----------------
    // Waits for the negedge where the scan is in digit d, prescaler phase p.
    task automatic wait_slot(input int d, input int p);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m_cyc % DIV) == p && ((m_cyc / DIV) % N) == d) break;
        end
        if (i == 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_slot: got timeout expected digit %0d phase %0d", d, p);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int i;
        reset_n  = 1'b0;
        value    = '0;
        dp_in    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'h0F);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_pending", 32'(pending), 32'h0);

        // Free-run scan order after reset.
        reset_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            check("an_seq", 32'(an), 32'(AN_SEQ[k]));
            if (k == 1) check("free_seg", 32'(seg), 32'(7'b1000000));
            @(negedge clk);
        end

        // Mid-frame load waits for the frame boundary.
        do_load(16'h12AF, 4'b0000);
        check("load_pending", 32'(pending), 32'h1);
        wait_slot(2, 2);
        check("still_pending", 32'(pending), 32'h1);
        check("old_display", 32'(seg), 32'(7'b1000000));
        wait_slot(0, 2);
        check("pending_cleared", 32'(pending), 32'h0);
        check("digit0_F", 32'(seg), 32'(7'b0001110));
        wait_slot(1, 2);
        check("digit1_A", 32'(seg), 32'(7'b0001000));
        wait_slot(2, 2);
        check("digit2_2", 32'(seg), 32'(7'b0100100));
        wait_slot(3, 2);
        check("digit3_1", 32'(seg), 32'(7'b1111001));
        check("digit3_an", 32'(an), 32'h7);

        // Decimal point on digit 2 only, never in a dead cycle.
        do_load(16'h12AF, 4'b0100);
        wait_slot(0, 1);
        for (int k = 0; k < FRAME; k++) begin
            check("dp_digit2", 32'(dp),
                  32'(!(((m_cyc / DIV) % N) == 2 && (m_cyc % DIV) != 0)));
            @(negedge clk);
        end

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        wait_slot(0, 1);
        wait_slot(1, 2);
        check("blank_d1_seg", 32'(seg), 32'(7'b0010010));
        check("blank_d1_an", 32'(an), 32'hD);
        wait_slot(2, 2);
        check("blank_d2_an", 32'(an), 32'hF);
        check("blank_d2_seg", 32'(seg), 32'h7F);
        wait_slot(3, 2);
        check("blank_d3_an", 32'(an), 32'hF);
        wait_slot(0, 2);
        check("blank_d0_seg", 32'(seg), 32'(7'b1000000));
        check("blank_d0_an", 32'(an), 32'hE);
        blank_lz = 1'b0;
        wait_slot(3, 2);
        check("noblank_d3_seg", 32'(seg), 32'(7'b1000000));
        check("noblank_d3_an", 32'(an), 32'h7);

        // Overwrite while pending: only the later value appears.
        wait_slot(0, 2);
        do_load(16'h1111, 4'b0000);
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        check("overwrite_pending", 32'(pending), 32'h1);
        wait_slot(0, 1);
        check("overwrite_cleared", 32'(pending), 32'h0);
        for (int k = 0; k < FRAME; k++) begin
            check("only_2222", 32'(seg), 32'(7'b0100100));
            @(negedge clk);
        end

        // Load landing exactly on the frame boundary replaces a pending value.
        wait_slot(1, 2);
        do_load(16'h4444, 4'b0000);
        check("coinc_pre_pending", 32'(pending), 32'h1);
        for (i = 0; i < 100; i++) begin
            if ((m_cyc % FRAME) == FRAME - 1) break;
            @(negedge clk);
        end
        if (i == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL coinc_wait: got timeout expected frame end");
        end
        do_load(16'h3333, 4'b0000);
        check("coinc_pending", 32'(pending), 32'h0);
        wait_slot(0, 2);
        check("coinc_d0", 32'(seg), 32'(7'b0110000));
        wait_slot(1, 2);
        check("coinc_d1", 32'(seg), 32'(7'b0110000));

        // Reset mid-slot with a value pending.
        wait_slot(1, 2);
        do_load(16'h5555, 4'b0000);
        check("rst_pre_pending", 32'(pending), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        reset_n = 1'b1;
        wait_slot(0, 2);
        check("rst_d0_seg", 32'(seg), 32'(7'b1000000));
        check("rst_d0_an", 32'(an), 32'hE);
        wait_slot(1, 2);
        check("rst_d1_seg", 32'(seg), 32'(7'b1000000));

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            load    = ($urandom_range(0, 5) == 0);
            value   = 16'($urandom_range(0, 16'hFFFF) >> (4 * $urandom_range(0, 4)));
            dp_in   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            reset_n = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        reset_n = 1'b1;
        load    = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
